// File: rtl/morse_symbol_ctrl_pkg.sv
// Types and default parameters shared by the Morse symbol controller files.
package morse_symbol_ctrl_pkg;
`include "morse_defs.vh"

   typedef enum logic [1:0] {
      ST_IDLE  = `MORSE_ST_IDLE,
      ST_PRESS = `MORSE_ST_PRESS,
      ST_GAP   = `MORSE_ST_GAP
   } state_e;

   localparam int CNT_W_DEF      = `MORSE_CNT_W_DEF;
   localparam int DOT_MAX_DEF    = `MORSE_DOT_MAX_DEF;
   localparam int LETTER_GAP_DEF = `MORSE_LETTER_GAP_DEF;
   localparam int WORD_GAP_DEF   = `MORSE_WORD_GAP_DEF;
endpackage

// File: rtl/key_edge_det.sv
// Registers the key level and derives single-cycle rise/fall strobes from it.
module key_edge_det (
   input  logic clk_i,
   input  logic reset_i,
   input  logic key_i,
   output logic rise_o,
   output logic fall_o
);
   logic key_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) key_q <= 1'b0;
      else         key_q <= key_i;
   end

   // Resetting key_q low makes a key held through reset appear as a fresh rise.
   assign rise_o = key_i & ~key_q;
   assign fall_o = ~key_i & key_q;
endmodule

// File: rtl/morse_defs.vh
// Shared FSM state encodings and default timing thresholds for the Morse symbol controller.
`ifndef MORSE_DEFS_VH
`define MORSE_DEFS_VH

`define MORSE_ST_IDLE          2'd0
`define MORSE_ST_PRESS         2'd1
`define MORSE_ST_GAP           2'd2

`define MORSE_CNT_W_DEF        8
`define MORSE_DOT_MAX_DEF      2
`define MORSE_LETTER_GAP_DEF   3
`define MORSE_WORD_GAP_DEF     7

`endif

// File: rtl/morse_symbol_ctrl.sv
// Classifies key presses into dots/dashes and key-up gaps into letter/word boundaries.
module morse_symbol_ctrl
   import morse_symbol_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DOT_MAX    = DOT_MAX_DEF,
   parameter int LETTER_GAP = LETTER_GAP_DEF,
   parameter int WORD_GAP   = WORD_GAP_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_in,
   input  logic tick,
   output logic sym_valid,
   output logic sym_is_dash,
   output logic letter_end,
   output logic word_end,
   output logic busy
);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] LETTER_C   = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0] WORD_C     = CNT_W'(WORD_GAP);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              sym_pend_q, sym_pend_d;
   logic              word_pend_q, word_pend_d;
   logic              sym_valid_q, sym_valid_d;
   logic              dash_q, dash_d;
   logic              letter_q, letter_d;
   logic              word_q, word_d;
   logic              busy_q;
   logic              rise, fall;

   key_edge_det u_edge (
      .clk_i   (clk),
      .reset_i (reset),
      .key_i   (key_in),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Edges are tested before ticks so an edge always clears cnt and masks thresholds.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sym_pend_d  = sym_pend_q;
      word_pend_d = word_pend_q;
      sym_valid_d = 1'b0;
      dash_d      = 1'b0;
      letter_d    = 1'b0;
      word_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_PRESS;
               cnt_d   = '0;
            end
         end
         ST_PRESS: begin
            if (fall) begin
               cnt_d = '0;
               if (cnt_q == '0) begin
                  state_d = sym_pend_q ? ST_GAP : ST_IDLE;
               end else begin
                  sym_valid_d = 1'b1;
                  dash_d      = (cnt_q > DOT_MAX_C);
                  sym_pend_d  = 1'b1;
                  state_d     = ST_GAP;
               end
            end else if (tick && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_inc;
            end
         end
         ST_GAP: begin
            if (rise) begin
               state_d = ST_PRESS;
               cnt_d   = '0;
            end else if (tick) begin
               cnt_d = cnt_inc;
               if ((cnt_inc == LETTER_C) && sym_pend_q) begin
                  letter_d    = 1'b1;
                  sym_pend_d  = 1'b0;
                  word_pend_d = 1'b1;
               end
               if (cnt_inc == WORD_C) begin
                  word_d      = word_pend_q;
                  word_pend_d = 1'b0;
                  cnt_d       = '0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sym_pend_q  <= 1'b0;
         word_pend_q <= 1'b0;
         sym_valid_q <= 1'b0;
         dash_q      <= 1'b0;
         letter_q    <= 1'b0;
         word_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sym_pend_q  <= sym_pend_d;
         word_pend_q <= word_pend_d;
         sym_valid_q <= sym_valid_d;
         dash_q      <= dash_d;
         letter_q    <= letter_d;
         word_q      <= word_d;
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign sym_valid   = sym_valid_q;
   assign sym_is_dash = dash_q;
   assign letter_end  = letter_q;
   assign word_end    = word_q;
   assign busy        = busy_q;
endmodule

// File: tb/tb_morse_symbol_ctrl.sv
// Scoreboard bench for morse_symbol_ctrl: stimulus queues expected pulses, a monitor retires them.
module tb_morse_symbol_ctrl;
   localparam int K_SYM  = 0;
   localparam int K_LET  = 1;
   localparam int K_WORD = 2;

   typedef struct {
      int   kind;
      logic dash;
      int   at;
   } ev_t;

   logic clk = 1'b0;
   logic reset, key_in, tick;
   logic sym_valid, sym_is_dash, letter_end, word_end, busy;
   logic slow_tick;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   F, F2;
   ev_t  exp_q[$];
   ev_t  me;
   int   mkind;

   morse_symbol_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .tick        (tick),
      .sym_valid   (sym_valid),
      .sym_is_dash (sym_is_dash),
      .letter_end  (letter_end),
      .word_end    (word_end),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tick = slow_tick ? ((cyc % 4) == 3) : 1'b1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic push(input int kind, input logic dash, input int at);
      ev_t e;
      e.kind = kind;
      e.dash = dash;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic check_all_low(input string tag);
      check({tag, "_sym_valid"}, int'(sym_valid), 0);
      check({tag, "_sym_is_dash"}, int'(sym_is_dash), 0);
      check({tag, "_letter_end"}, int'(letter_end), 0);
      check({tag, "_word_end"}, int'(word_end), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   // Monitor: every output pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (sym_valid === 1'b1 || letter_end === 1'b1 || word_end === 1'b1) begin
         mkind = sym_valid ? K_SYM : (letter_end ? K_LET : K_WORD);
         check("pulse_one_hot", int'(sym_valid) + int'(letter_end) + int'(word_end), 1);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_kind", mkind, -1);
         end else begin
            me = exp_q.pop_front();
            check("pulse_kind", mkind, me.kind);
            check("pulse_cycle", cyc, me.at);
            if (me.kind == K_SYM) check("sym_is_dash", int'(sym_is_dash), int'(me.dash));
         end
      end
   end

   initial begin
      reset = 1'b1; key_in = 1'b0; tick = 1'b1; slow_tick = 1'b0;
      steps(2);
      check_all_low("reset");
      reset = 1'b0;
      step();

      // Dot of 2 ticks followed by a full word gap.
      key_in = 1'b1; steps(3);
      key_in = 1'b0; F = cyc + 1;
      push(K_SYM, 1'b0, F); push(K_LET, 1'b0, F + 3); push(K_WORD, 1'b0, F + 7);
      steps(F + 3 - cyc);
      check("busy_in_gap", int'(busy), 1);
      steps(5);
      check("busy_after_word", int'(busy), 0);

      // Dash of 4 ticks, letter gap only, then reset mid-gap.
      key_in = 1'b1; steps(5);
      key_in = 1'b0; F = cyc + 1;
      push(K_SYM, 1'b1, F); push(K_LET, 1'b0, F + 3);
      steps(F + 3 - cyc);
      check("busy_after_letter", int'(busy), 1);
      steps(2);
      reset = 1'b1; steps(2);
      check_all_low("gap_reset");
      reset = 1'b0; steps(10);
      check("busy_idle_after_gap_reset", int'(busy), 0);

      // Single-cycle glitch with a slow time base.
      slow_tick = 1'b1;
      step();
      while (tick != 1'b1) step();
      step();
      key_in = 1'b1; step();
      check("busy_glitch_press", int'(busy), 1);
      key_in = 1'b0; step();
      check("busy_glitch_idle", int'(busy), 0);
      steps(8);
      check("busy_glitch_settled", int'(busy), 0);
      slow_tick = 1'b0; step();

      // Re-press at gap cnt=2 joins the letter; second symbol must still be a dot.
      key_in = 1'b1; steps(3);
      key_in = 1'b0; F = cyc + 1;
      push(K_SYM, 1'b0, F);
      steps(F + 2 - cyc);
      key_in = 1'b1; steps(3);
      key_in = 1'b0; F2 = cyc + 1;
      push(K_SYM, 1'b0, F2); push(K_LET, 1'b0, F2 + 3); push(K_WORD, 1'b0, F2 + 7);
      steps(F2 + 8 - cyc);
      check("busy_after_joined_word", int'(busy), 0);

      // Reset at PRESS cnt=3 with key held, then a fresh dot.
      key_in = 1'b1; steps(4);
      reset = 1'b1; steps(2);
      check_all_low("press_reset");
      reset = 1'b0; step();
      check("busy_press_after_reset", int'(busy), 1);
      steps(2);
      key_in = 1'b0; F = cyc + 1;
      push(K_SYM, 1'b0, F); push(K_LET, 1'b0, F + 3); push(K_WORD, 1'b0, F + 7);
      steps(F + 8 - cyc);
      check("busy_final", int'(busy), 0);

      steps(3);
      check("expected_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
